// File: rtl/toast_mem_arbiter.sv
// Two-master (fetch/data) arbiter for a single-port synchronous memory.
// Data has priority; a saturating starvation counter periodically forces a fetch grant.
module toast_mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int STARVE_MAX = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [31:0]       if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [31:0]       if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [3:0]        d_be_i,
  input  logic [31:0]       d_addr_i,
  input  logic [31:0]       d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [31:0]       d_rdata_o,
  output logic              mem_en_o,
  output logic [3:0]        mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
);

  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DRD, OWN_DWR} owner_t;

  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  logic [2:0] r_starve;
  owner_t     r_owner_p1;
  logic       w_if_gnt;
  logic       w_d_gnt;
  logic       w_unused;

  assign w_unused = ^{if_addr_i[31:ADDR_W+2], if_addr_i[1:0],
                      d_addr_i[31:ADDR_W+2], d_addr_i[1:0]};

  // Stage p0: grant decision and memory request, all combinational
  always_comb begin
    w_if_gnt = 1'b0;
    w_d_gnt  = 1'b0;
    if (!rst_i) begin
      w_if_gnt = if_req_i && (!d_req_i || (r_starve >= STARVE_LIM));
      w_d_gnt  = d_req_i && !w_if_gnt;
    end
  end

  assign if_gnt_o = w_if_gnt;
  assign d_gnt_o  = w_d_gnt;

  always_comb begin
    mem_en_o    = w_if_gnt | w_d_gnt;
    mem_we_o    = 4'b0000;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (w_if_gnt) begin
      mem_addr_o = if_addr_i[ADDR_W+1:2];
    end else if (w_d_gnt) begin
      mem_addr_o = d_addr_i[ADDR_W+1:2];
      if (d_we_i) begin
        mem_we_o    = d_be_i;
        mem_wdata_o = d_wdata_i;
      end
    end
  end

  // Counts data grants that bypassed a waiting fetch; never passes the limit
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_starve <= 3'd0;
    end else if (!if_req_i || w_if_gnt) begin
      r_starve <= 3'd0;
    end else if (w_d_gnt && (r_starve < STARVE_LIM)) begin
      r_starve <= r_starve + 3'd1;
    end
  end

  // Stage p1: response owner, one cycle behind the grant
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_owner_p1 <= OWN_NONE;
    end else if (w_if_gnt) begin
      r_owner_p1 <= OWN_IF;
    end else if (w_d_gnt) begin
      r_owner_p1 <= d_we_i ? OWN_DWR : OWN_DRD;
    end else begin
      r_owner_p1 <= OWN_NONE;
    end
  end

  // Gating with rst_i drops a response whose grant landed just before reset
  assign if_rvalid_o = !rst_i && (r_owner_p1 == OWN_IF);
  assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : 32'd0;
  assign d_rvalid_o  = !rst_i && ((r_owner_p1 == OWN_DRD) || (r_owner_p1 == OWN_DWR));
  assign d_rdata_o   = (!rst_i && (r_owner_p1 == OWN_DRD)) ? mem_rdata_i : 32'd0;

endmodule

// File: tb/tb_toast_mem_arbiter.sv
// Self-checking bench for toast_mem_arbiter: directed scenarios plus a randomized
// run against a transaction-level reference model with its own golden memory.
module tb_toast_mem_arbiter;

  localparam int ADDR_W     = 16;
  localparam int STARVE_MAX = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              if_req = 1'b0;
  logic [31:0]       if_addr = '0;
  logic              if_gnt, if_rvalid;
  logic [31:0]       if_rdata;
  logic              d_req = 1'b0, d_we = 1'b0;
  logic [3:0]        d_be = '0;
  logic [31:0]       d_addr = '0, d_wdata = '0;
  logic              d_gnt, d_rvalid;
  logic [31:0]       d_rdata;
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata = '0;

  logic              pre_en = 1'b0;
  logic [ADDR_W-1:0] pre_addr = '0;
  logic [31:0]       pre_data = '0;

  logic [31:0] mem     [0:(1<<ADDR_W)-1];
  logic [31:0] ref_mem [0:(1<<ADDR_W)-1];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  toast_mem_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .d_req_i(d_req), .d_we_i(d_we), .d_be_i(d_be), .d_addr_i(d_addr),
    .d_wdata_i(d_wdata), .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  // Synchronous single-port memory seen by the DUT (read returns the pre-write word)
  always @(posedge clk) begin
    if (pre_en) begin
      mem[pre_addr] <= pre_data;
    end else if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= mem[mem_addr];
    end
  end

  task automatic preload();
    logic [31:0] v;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      pre_en   = 1'b1;
      pre_addr = (i == 8) ? 16'h0004 : 16'(16'h0800 + i);
      v        = (i == 8) ? 32'hDEAD_BEEF : $urandom;
      pre_data = v;
      ref_mem[pre_addr] = v;
    end
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      rst = 1'b1; if_req = 1'b1; if_addr = 32'h10;
      d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h2000;
      #1;
      n_checks++;
      if ({if_gnt, d_gnt, mem_en, mem_we} !== 7'b0) begin
        n_fail++;
        $display("FAIL reset_grants: got gnt=%b%b en=%b we=%b required all 0", if_gnt, d_gnt, mem_en, mem_we);
      end
      n_checks++;
      if ({if_rvalid, d_rvalid, if_rdata, d_rdata} !== 66'b0) begin
        n_fail++;
        $display("FAIL reset_resp: got rvalid=%b%b rdata=%h/%h required 0", if_rvalid, d_rvalid, if_rdata, d_rdata);
      end
    end
  endtask

  task automatic test_fetch();
    @(negedge clk);
    rst = 1'b0; d_req = 1'b0; d_we = 1'b0; d_be = 4'h0;
    if_req = 1'b1; if_addr = 32'h0000_0010;
    #1;
    n_checks++;
    if ({if_gnt, d_gnt, mem_en, mem_we} !== 7'b1010000 || mem_addr !== 16'h0004) begin
      n_fail++;
      $display("FAIL fetch_grant: got gnt=%b%b en=%b we=%b addr=%h required 101 0000 0004", if_gnt, d_gnt, mem_en, mem_we, mem_addr);
    end
    @(negedge clk);
    if_req = 1'b0;
    #1;
    n_checks++;
    if (if_rvalid !== 1'b1 || if_rdata !== 32'hDEAD_BEEF || d_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_resp: got rvalid=%b rdata=%h d_rvalid=%b required 1 deadbeef 0", if_rvalid, if_rdata, d_rvalid);
    end
  endtask

  task automatic test_store();
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h2000; d_wdata = 32'h1234_5678;
    #1;
    n_checks++;
    if ({if_gnt, d_gnt, mem_en, mem_we} !== 7'b0110011 || mem_addr !== 16'h0800 || mem_wdata !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL store_grant: got gnt=%b%b en=%b we=%b addr=%h wdata=%h required 011 0011 0800 12345678", if_gnt, d_gnt, mem_en, mem_we, mem_addr, mem_wdata);
    end
    ref_mem[16'h0800][15:0] = 16'h5678;
    @(negedge clk);
    d_req = 1'b0; d_we = 1'b0;
    #1;
    n_checks++;
    if (d_rvalid !== 1'b1 || d_rdata !== 32'd0 || if_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL store_ack: got d_rvalid=%b d_rdata=%h if_rvalid=%b required 1 0 0", d_rvalid, d_rdata, if_rvalid);
    end
  endtask

  task automatic test_store_load();
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h2004; d_wdata = 32'hA5A5_A5A5;
    #1;
    ref_mem[16'h0801] = 32'hA5A5_A5A5;
    @(negedge clk);
    d_we = 1'b0; d_wdata = 32'h0;
    #1;
    n_checks++;
    if (d_gnt !== 1'b1 || mem_we !== 4'b0 || mem_addr !== 16'h0801) begin
      n_fail++;
      $display("FAIL b2b_load_grant: got gnt=%b we=%b addr=%h required 1 0000 0801", d_gnt, mem_we, mem_addr);
    end
    n_checks++;
    if (d_rvalid !== 1'b1 || d_rdata !== 32'd0) begin
      n_fail++;
      $display("FAIL b2b_store_ack: got rvalid=%b rdata=%h required 1 0", d_rvalid, d_rdata);
    end
    @(negedge clk);
    d_req = 1'b0;
    #1;
    n_checks++;
    if (d_rvalid !== 1'b1 || d_rdata !== 32'hA5A5_A5A5) begin
      n_fail++;
      $display("FAIL store_then_load: got rvalid=%b rdata=%h required 1 a5a5a5a5", d_rvalid, d_rdata);
    end
  endtask

  task automatic test_starvation();
    logic exp_if;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h0000_2008;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_200C;
      #1;
      exp_if = (c % 3) == 2;
      n_checks++;
      if (if_gnt !== exp_if || d_gnt !== !exp_if) begin
        n_fail++;
        $display("FAIL starve_seq[%0d]: got if_gnt=%b d_gnt=%b required %b %b", c, if_gnt, d_gnt, exp_if, !exp_if);
      end
    end
    @(negedge clk);
    if_req = 1'b0; d_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2004;
    #1;
    n_checks++;
    if (d_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_grant: got d_gnt=%b required 1", d_gnt);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({if_gnt, d_gnt, mem_en, mem_we, if_rvalid, d_rvalid} !== 9'b0 || d_rdata !== 32'd0 || if_rdata !== 32'd0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got gnt=%b%b en=%b we=%b rvalid=%b%b d_rdata=%h required all 0", if_gnt, d_gnt, mem_en, mem_we, if_rvalid, d_rvalid, d_rdata);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (d_gnt !== 1'b1 || mem_addr !== 16'h0801 || d_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_release_regrant: got gnt=%b addr=%h rvalid=%b required 1 0801 0", d_gnt, mem_addr, d_rvalid);
    end
    @(negedge clk);
    d_req = 1'b0;
    #1;
    n_checks++;
    if (d_rvalid !== 1'b1 || d_rdata !== 32'hA5A5_A5A5) begin
      n_fail++;
      $display("FAIL rst_release_resp: got rvalid=%b rdata=%h required 1 a5a5a5a5", d_rvalid, d_rdata);
    end
  endtask

  task automatic test_if_drop();
    logic [4:0] ifr_pat = 5'b11101;
    logic [4:0] exp_if  = 5'b10000;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if_req = ifr_pat[c]; if_addr = 32'h0000_2010;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_2014;
      #1;
      n_checks++;
      if (if_gnt !== exp_if[c] || d_gnt !== !exp_if[c]) begin
        n_fail++;
        $display("FAIL if_drop[%0d]: got if_gnt=%b d_gnt=%b required %b %b", c, if_gnt, d_gnt, exp_if[c], !exp_if[c]);
      end
    end
    @(negedge clk);
    if_req = 1'b0; d_req = 1'b0;
  endtask

  task automatic test_random();
    logic ip = 1'b0, dp = 1'b0, dwe = 1'b0;
    logic [31:0] ia = '0, da = '0, dwd = '0;
    logic [3:0] dbe = '0;
    int streak = 0;
    int pk = 0;
    logic [31:0] pd = '0;
    logic ifw, dw;
    logic [15:0] ea;
    logic [3:0] ewe;
    logic [31:0] ewd;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!ip && $urandom_range(0, 99) < 55) begin
        ip = 1'b1;
        ia = ((32'h800 + $urandom_range(0, 7)) << 2) | $urandom_range(0, 3);
      end
      if (!dp && $urandom_range(0, 99) < 70) begin
        dp  = 1'b1;
        da  = ((32'h800 + $urandom_range(0, 7)) << 2) | $urandom_range(0, 3);
        dwe = $urandom_range(0, 1) == 1;
        dbe = 4'($urandom_range(0, 15));
        dwd = $urandom;
      end
      if_req = ip; if_addr = ia;
      d_req = dp; d_we = dwe; d_be = dbe; d_addr = da; d_wdata = dwd;
      #1;
      ifw = ip && (!dp || streak >= STARVE_MAX);
      dw  = dp && !ifw;
      ea  = ifw ? ia[17:2] : (dw ? da[17:2] : 16'h0);
      ewe = (dw && dwe) ? dbe : 4'h0;
      ewd = (dw && dwe) ? dwd : 32'h0;
      n_checks++;
      if (if_gnt !== ifw || d_gnt !== dw) begin
        n_fail++;
        $display("FAIL rnd_grant[%0d]: got %b%b required %b%b", c, if_gnt, d_gnt, ifw, dw);
      end
      n_checks++;
      if (mem_en !== (ifw || dw) || mem_addr !== ea || mem_we !== ewe || mem_wdata !== ewd) begin
        n_fail++;
        $display("FAIL rnd_mem[%0d]: got en=%b addr=%h we=%b wd=%h required %b %h %b %h", c, mem_en, mem_addr, mem_we, mem_wdata, ifw || dw, ea, ewe, ewd);
      end
      n_checks++;
      if (if_rvalid !== (pk == 1) || d_rvalid !== (pk >= 2) ||
          if_rdata !== ((pk == 1) ? pd : 32'h0) || d_rdata !== ((pk == 2) ? pd : 32'h0)) begin
        n_fail++;
        $display("FAIL rnd_resp[%0d]: got rv=%b%b rd=%h/%h required kind=%0d data=%h", c, if_rvalid, d_rvalid, if_rdata, d_rdata, pk, pd);
      end
      pk = 0; pd = '0;
      if (ifw) begin
        pk = 1; pd = ref_mem[ia[17:2]];
      end else if (dw && !dwe) begin
        pk = 2; pd = ref_mem[da[17:2]];
      end else if (dw) begin
        pk = 3;
        for (int b = 0; b < 4; b++)
          if (dbe[b]) ref_mem[da[17:2]][8*b +: 8] = dwd[8*b +: 8];
      end
      if (!ip || ifw) streak = 0;
      else if (dw && streak < STARVE_MAX) streak++;
      if (ifw) ip = 1'b0;
      if (dw) dp = 1'b0;
    end
    @(negedge clk);
    if_req = 1'b0; d_req = 1'b0;
  endtask

  initial begin
    preload();
    test_reset();
    test_fetch();
    test_store();
    test_store_load();
    test_starvation();
    test_reset_mid();
    test_if_drop();
    test_random();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
